// File: rtl/register_dump_uart.sv
// Register-file dump engine: strobes each debug address in turn and streams the
// captured 32-bit word out as four 8N1 UART bytes, most significant byte first.
module register_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_out_debug,
  output logic [4:0]  read_address_debug,
  output logic        clock_debug,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // NEXT occupies the final cycle of the last stop bit, so the exit fires one cycle early.
  localparam logic [BW-1:0] BAUD_EXIT = BW'(CLKS_PER_BIT - 2);
  localparam logic [4:0]    ADDR_LAST = 5'(NUM_REGS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_STROBE_HI = 3'd1;
  localparam logic [2:0] S_STROBE_LO = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic          strobe_q, strobe_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_q, load_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    sr_q, sr_d;

  // Next-state logic for sequencing, strobe generation and serialization.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    strobe_d = 1'b0;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_d   = load_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    word_d   = word_q;
    sr_d     = sr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          state_d = S_STROBE_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STROBE_HI: begin
        strobe_d = 1'b1;
        state_d  = S_STROBE_LO;
      end
      S_STROBE_LO: begin
        load_d  = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (load_q) begin
          load_d = 1'b0;
          word_d = data_out_debug;
          sr_d   = data_out_debug[31:24];
          tx_d   = 1'b0;
          baud_d = {BW{1'b0}};
          bit_d  = 4'd0;
          byte_d = 2'd0;
        end else if (baud_q == BAUD_LAST) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 4'd9) begin
            bit_d  = 4'd0;
            byte_d = byte_q + 2'd1;
            word_d = {word_q[23:0], 8'h00};
            sr_d   = word_q[23:16];
            tx_d   = 1'b0;
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d = sr_q[0];
              sr_d = {1'b0, sr_q[7:1]};
            end
          end
        end else begin
          baud_d = baud_q + BW'(1);
          if (byte_q == 2'd3 && bit_q == 4'd9 && baud_q == BAUD_EXIT) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_NEXT: begin
        baud_d = {BW{1'b0}};
        bit_d  = 4'd0;
        byte_d = 2'd0;
        if (addr_q == ADDR_LAST) begin
          addr_d  = 5'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 5'd1;
          state_d = S_STROBE_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous abort to idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 5'd0;
      strobe_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      baud_q   <= {BW{1'b0}};
      bit_q    <= 4'd0;
      byte_q   <= 2'd0;
      word_q   <= 32'd0;
      sr_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      sr_q     <= sr_d;
    end
  end

  assign read_address_debug = addr_q;
  assign clock_debug        = strobe_q;
  assign tx                 = tx_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_register_dump_uart.sv
// Bench for register_dump_uart: a register-file model feeds the debug port and every
// output is compared each cycle against a timeline computed from the frame arithmetic.
module tb_register_dump_uart;

  logic        clock;
  logic        reset;
  logic        start_a, start_b;
  logic [31:0] data_a, data_b;
  logic [4:0]  addr_a, addr_b;
  logic        cd_a, cd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  int vectors;
  int miscompares;

  register_dump_uart #(.CLKS_PER_BIT(4), .NUM_REGS(32)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .data_out_debug(data_a),
    .read_address_debug(addr_a), .clock_debug(cd_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  register_dump_uart #(.CLKS_PER_BIT(434), .NUM_REGS(1)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .data_out_debug(data_b),
    .read_address_debug(addr_b), .clock_debug(cd_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Register file debug ports update on the rise of their debug clock.
  always @(posedge cd_a) data_a <= regs_a[addr_a];
  always @(posedge cd_b) data_b <= regs_b[addr_b];

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Expected tx level t cycles after the accepting edge, from frame arithmetic.
  function automatic logic exp_tx(input int t, input int c, input int n, input logic [31:0] w [32]);
    int p, k, off, bp, by, bi;
    logic [31:0] word;
    p = 3 + 40 * c;
    if (t < 3) return 1'b1;
    k   = (t - 3) / p;
    off = (t - 3) - k * p;
    if (k >= n || off >= 40 * c) return 1'b1;
    bp = off / c;
    by = bp / 10;
    bi = bp % 10;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    word = w[k];
    return word[8 * (3 - by) + (bi - 1)];
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_a"},   0, 32'(tx_a),   32'd1);
    chk({tag, "_busy_a"}, 0, 32'(busy_a), 32'd0);
    chk({tag, "_done_a"}, 0, 32'(done_a), 32'd0);
    chk({tag, "_cd_a"},   0, 32'(cd_a),   32'd0);
    chk({tag, "_addr_a"}, 0, 32'(addr_a), 32'd0);
    chk({tag, "_tx_b"},   0, 32'(tx_b),   32'd1);
    chk({tag, "_busy_b"}, 0, 32'(busy_b), 32'd0);
  endtask

  // One dump checked cycle by cycle; optional long start hold, mid-dump re-pulse, early exit.
  task automatic run_dump(input bit sel, input logic [31:0] w [32], input int c, input int n,
                          input int hold, input int repulse, input int abort_at);
    int p, last, k;
    logic o_tx, o_cd, o_busy, o_done, e_cd;
    logic [4:0] o_addr;
    p    = 3 + 40 * c;
    last = n * p + 3;
    @(negedge clock);
    set_start(sel, 1'b1);
    @(posedge clock);
    #1;
    for (int t = 0; t <= last; t++) begin
      if (t == hold - 1 || t == repulse + 1) set_start(sel, 1'b0);
      if (t == repulse) set_start(sel, 1'b1);
      o_tx   = sel ? tx_b   : tx_a;
      o_cd   = sel ? cd_b   : cd_a;
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      o_addr = sel ? addr_b : addr_a;
      k      = (t - 1) / p;
      e_cd   = (t >= 1 && (t - 1) % p == 0 && k < n);
      chk("tx",   t, 32'(o_tx),   32'(exp_tx(t, c, n, w)));
      chk("strb", t, 32'(o_cd),   32'(e_cd));
      chk("busy", t, 32'(o_busy), 32'(t < n * p));
      chk("done", t, 32'(o_done), 32'(t == n * p));
      if (o_cd) chk("addr", t, 32'(o_addr), 32'(k));
      if (t == n * p) chk("addr_end", t, 32'(o_addr), 32'd0);
      if (t == abort_at) begin
        set_start(sel, 1'b0);
        return;
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start_a     = 1'b0;
    start_b     = 1'b0;
    data_a      = 32'd0;
    data_b      = 32'd0;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = 32'(i);
      regs_b[i] = 32'd0;
    end

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst0");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Full dump of Registers[i]=i.
    run_dump(1'b0, regs_a, 4, 32, 1, -1, -1);

    // Random contents with 0xDEADBEEF at 5; start held 10 cycles and re-pulsed mid-dump.
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    regs_a[5] = 32'hDEADBEEF;
    run_dump(1'b0, regs_a, 4, 32, 10, 2000, -1);

    // Abort inside the third byte of register 7.
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    run_dump(1'b0, regs_a, 4, 32, 1, -1, 3 + 7 * 163 + 20 * 4 + 5);
    #2 reset = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clock);
      #1;
      chk("abort_done", t, 32'(done_a), 32'd0);
      chk("abort_tx",   t, 32'(tx_a),   32'd1);
    end

    // Fresh dump after the abort restarts at address 0 with the normal latency.
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    run_dump(1'b0, regs_a, 4, 32, 1, -1, -1);

    // Default bit time with a single register.
    regs_b[0] = $urandom;
    run_dump(1'b1, regs_b, 434, 1, 1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_dump_uart.md
# register_dump_uart

Debug-side reader for the CPU register file's debug port. On a `start` pulse it walks register addresses 0 to NUM_REGS-1 and pulses `clock_debug` once per register. It captures `data_out_debug` and serializes each 32-bit word as four 8N1 UART bytes, most significant byte first, on `tx`. It sits beside the register file at the top level and gives a host a full register snapshot without halting the datapath clock.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- NUM_REGS, 32, registers dumped per request; legal range 1..32.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  dump request; sampled only in IDLE.
- data_out_debug  in  32  register word returned by the register file's debug port.
- read_address_debug  out  5  register address being read; registered.
- clock_debug  out  1  one-cycle-high read strobe to the register file's debug clock; registered, glitch-free.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high from start acceptance until the dump completes.
- done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values:
  - tx=1, busy=0, done=0, clock_debug=0, read_address_debug=0.
  - State IDLE; baud, bit and byte counters 0.
- States: IDLE, STROBE_HI, STROBE_LO, SEND, NEXT.
- IDLE: on start=1, set busy=1 and go to STROBE_HI. read_address_debug is already 0.
- STROBE_HI: clock_debug←1, go to STROBE_LO.
- STROBE_LO: clock_debug←0, go to SEND.
- SEND:
  - On entry, latch data_out_debug into a 32-bit shift word and begin the start bit (tx←0).
  - Per byte: start bit 0, eight data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes go out in order [31:24], [23:16], [15:8], [7:0], back-to-back with no idle gap.
- After the fourth stop bit:
  - If address < NUM_REGS-1: increment address, go to STROBE_HI via NEXT; tx stays 1.
  - Otherwise: address←0, busy←0, done←1 for one cycle, go to IDLE.
- start is ignored while busy=1; a held-high start begins exactly one dump.
- A new dump may begin on the cycle after done.
- Reset mid-operation aborts immediately, returning all outputs to their reset values. A partial byte is abandoned (tx forced high) and no done is issued.
- The baud counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.
- The shift word captures exactly once per register, in the first SEND cycle. data_out_debug is don't-care at all other times.

## Timing
- Let E0 be the edge at which start is accepted.
- clock_debug is high during cycle E1→E2; the register file updates data_out_debug at that rise.
- The capture at E3 is two clocks after the strobe rise, so data is stable.
- tx falls (start bit) at E3, a fixed 3-cycle latency from start acceptance.
- Per register: 3 strobe cycles + 40·CLKS_PER_BIT transmit cycles, with a 3-cycle tx-high gap between consecutive registers.
- Register k's start bit begins at E3 + k·(3+40·CLKS_PER_BIT).
- done=1 and busy=0 at E0 + NUM_REGS·(3+40·CLKS_PER_BIT).
- read_address_debug changes only at the NEXT transition and never while clock_debug=1.

## Test plan
- Reset: assert reset mid-clock → tx=1, busy=0, done=0, clock_debug=0, read_address_debug=0 without waiting for a clock edge.
- Full dump:
  - Setup: CLKS_PER_BIT=4; register model preloaded with Registers[i]=i.
  - One-cycle start at E0 → tx falls at E3; first four bytes 00 00 00 00; bytes 5–8 00 00 00 01; 128 bytes total.
  - clock_debug shows exactly 32 one-cycle pulses at addresses 0..31 in order.
  - done pulses once at E0+5216.
- Byte/bit order: Registers[5]=0xDEADBEEF → register 5 frame is DE AD BE EF. The EF byte's data bits on tx are 1,1,1,1,0,1,1,1, each bit exactly 4 cycles, stop bit high.
- Start handling: start held high 10 cycles, then pulsed again mid-dump → exactly one dump. busy stays high throughout, and no extra clock_debug pulses occur.
- Abort: reset asserted during the third byte of register 7, then start → tx high immediately, no done. The new dump starts at address 0 with a clean 3-cycle latency.
- Default baud: CLKS_PER_BIT=434, NUM_REGS=1 → each bit 434 cycles; done at E0+3+17360.
